// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I decode definitions: major opcode values and the immediate
// format encoding used by the immediate generator and its consumers.
// No ports (package).
// ----------------------------------------------------------------------------
package rv32_pkg;

   // Major opcodes, instr[6:0]
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Immediate format code, 3 bits
   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

endpackage : rv32_pkg

// File: rtl/imm_gen_dec.sv
// ----------------------------------------------------------------------------
// imm_gen_dec
// Combinational opcode -> immediate format decoder.
// Optional feature macro: IMM_GEN_ZICSR_EN
//   defined     : SYSTEM with funct3[2]=1 (immediate CSR ops) decodes as Z
//   not defined : every SYSTEM word decodes as I, Z is never produced
// Ports:
//   opcode     in  7  instr[6:0]
//   funct3_msb in  1  instr[14]
//   fmt        out 3  decoded format (imm_fmt_e)
// ----------------------------------------------------------------------------
module imm_gen_dec
   import rv32_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic       funct3_msb,
   output imm_fmt_e   fmt
);

`ifndef IMM_GEN_ZICSR_EN
   // funct3 only matters for the CSR-immediate split
   logic w_unused_funct3_msb;
   assign w_unused_funct3_msb = funct3_msb;
`endif

   // Opcode to format lookup; anything unrecognised is NONE
   always_comb begin
      fmt = FMT_NONE;
      case (opcode)
         OPC_OP_IMM,
         OPC_LOAD,
         OPC_JALR:   fmt = FMT_I;
         OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
            if (funct3_msb) begin
               fmt = FMT_Z;
            end else begin
               fmt = FMT_I;
            end
`else
            fmt = FMT_I;
`endif
         end
         OPC_STORE:  fmt = FMT_S;
         OPC_BRANCH: fmt = FMT_B;
         OPC_LUI,
         OPC_AUIPC:  fmt = FMT_U;
         OPC_JAL:    fmt = FMT_J;
         default:    fmt = FMT_NONE;
      endcase
   end

endmodule : imm_gen_dec

// File: rtl/imm_gen.sv
// ----------------------------------------------------------------------------
// imm_gen
// RV32I decode-stage immediate generator. Produces the extended immediate and
// its format combinationally, plus a registered copy for the ID/EX boundary.
// Optional feature macro: IMM_GEN_ZICSR_EN (zero-extended CSR uimm, format Z).
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous active-high reset
//   instr       in   32  raw instruction word
//   instr_valid in   1   instr carries a real instruction this cycle
//   imm         out  32  combinational immediate
//   fmt         out  3   combinational format code
//   imm_q       out  32  imm captured when instr_valid
//   fmt_q       out  3   fmt captured when instr_valid
//   valid_q     out  1   instr_valid delayed one cycle
// ----------------------------------------------------------------------------
module imm_gen
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] instr,
   input  logic            instr_valid,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic [XLEN-1:0] imm_q,
   output logic [2:0]      fmt_q,
   output logic            valid_q
);

   if (XLEN != 32) begin : g_xlen_check
      $error("imm_gen: only XLEN=32 is supported");
   end

   imm_fmt_e        w_fmt;
   logic [31:0]     w_imm;
   logic            w_sign;
   logic [31:0]     r_imm_q;
   logic [2:0]      r_fmt_q;
   logic            r_valid_q;

   // funct3[1:0] never affects the immediate
   logic w_unused_funct3_lo;
   assign w_unused_funct3_lo = ^instr[13:12];

   assign w_sign = instr[31];

   imm_gen_dec u_dec (
      .opcode     (instr[6:0]),
      .funct3_msb (instr[14]),
      .fmt        (w_fmt)
   );

   // Format-selected field assembly and extension
   always_comb begin
      w_imm = 32'h0000_0000;
      case (w_fmt)
         FMT_I:   w_imm = {{20{w_sign}}, instr[31:20]};
         FMT_S:   w_imm = {{20{w_sign}}, instr[31:25], instr[11:7]};
         FMT_B:   w_imm = {{19{w_sign}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         FMT_U:   w_imm = {instr[31:12], 12'h000};
         FMT_J:   w_imm = {{11{w_sign}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         // Only reachable when the decoder emits Z
         FMT_Z:   w_imm = {27'h000_0000, instr[19:15]};
         FMT_NONE: w_imm = 32'h0000_0000;
         default: w_imm = 32'h0000_0000;
      endcase
   end

   assign imm = w_imm;
   assign fmt = w_fmt;

   // ID/EX capture: valid always follows, payload holds on bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_imm_q   <= 32'h0000_0000;
         r_fmt_q   <= 3'd0;
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= instr_valid;
         if (instr_valid) begin
            r_imm_q <= w_imm;
            r_fmt_q <= w_fmt;
         end
      end
   end

   assign imm_q   = r_imm_q;
   assign fmt_q   = r_fmt_q;
   assign valid_q = r_valid_q;

endmodule : imm_gen

// File: tb/tb_imm_gen.sv
// ----------------------------------------------------------------------------
// tb_imm_gen
// Self-checking bench for imm_gen: table of instruction words with expected
// immediate/format, a scoreboard queue for the registered stage, and short
// hand-written sequences for hold and asynchronous reset behaviour.
// ----------------------------------------------------------------------------
module tb_imm_gen;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] imm;
   logic [2:0]  fmt;
   logic [31:0] imm_q;
   logic [2:0]  fmt_q;
   logic        valid_q;

   int tests_run;
   int tests_failed;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] imm;
      logic [2:0]  fmt;
   } vec_t;

   typedef struct {
      logic [31:0] imm;
      logic [2:0]  fmt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   localparam logic [2:0] F_NONE = 3'd0;
   localparam logic [2:0] F_I    = 3'd1;
   localparam logic [2:0] F_S    = 3'd2;
   localparam logic [2:0] F_B    = 3'd3;
   localparam logic [2:0] F_U    = 3'd4;
   localparam logic [2:0] F_J    = 3'd5;
   localparam logic [2:0] F_Z    = 3'd6;

   imm_gen #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .imm         (imm),
      .fmt         (fmt),
      .imm_q       (imm_q),
      .fmt_q       (fmt_q),
      .valid_q     (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string n, input logic [31:0] i, input logic [31:0] m, input logic [2:0] f);
      vec_t v;
      v.name = n; v.instr = i; v.imm = m; v.fmt = f;
      vecs.push_back(v);
   endtask

   initial begin
      exp_t e;
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      instr        = 32'h0000_0000;
      instr_valid  = 1'b0;

      add("addi_m5",   32'hFFB1_0093, 32'hFFFF_FFFB, F_I);
      add("sw_m8",     32'hFE30_AC23, 32'hFFFF_FFF8, F_S);
      add("beq_m4",    32'hFE20_8EE3, 32'hFFFF_FFFC, F_B);
      add("lui",       32'h1234_50B7, 32'h1234_5000, F_U);
      add("jal_m8",    32'hFF9F_F0EF, 32'hFFFF_FFF8, F_J);
      add("lw_16",     32'h0101_2283, 32'h0000_0010, F_I);
      add("jalr_0",    32'h0000_8067, 32'h0000_0000, F_I);
      add("auipc",     32'hFFFF_F097, 32'hFFFF_F000, F_U);
      add("slli_31",   32'h01F1_1093, 32'h0000_001F, F_I);
      add("srai_3",    32'h4031_5093, 32'h0000_0403, F_I);
      add("beq_p8",    32'h0000_0463, 32'h0000_0008, F_B);
      add("b_bit11",   32'h0000_00E3, 32'h0000_0800, F_B);
      add("j_bit11",   32'h0010_006F, 32'h0000_0800, F_J);
      add("j_bit12",   32'h0000_106F, 32'h0000_1000, F_J);
      add("illegal",   32'hFFFF_FFFF, 32'h0000_0000, F_NONE);
      add("ecall",     32'h0000_0073, 32'h0000_0000, F_I);
      add("csrrw",     32'h3001_10F3, 32'h0000_0300, F_I);
`ifdef IMM_GEN_ZICSR_EN
      add("csrrwi",    32'h3002_D073, 32'h0000_0005, F_Z);
`else
      add("csrrwi",    32'h3002_D073, 32'h0000_0300, F_I);
`endif

      // Reset state, and combinational path alive during reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_imm_q",   imm_q,          32'h0000_0000);
      chk("rst_fmt_q",   {29'd0, fmt_q}, 32'h0000_0000);
      chk("rst_valid_q", {31'd0, valid_q}, 32'h0000_0000);
      instr = 32'hFFB1_0093;
      #1;
      chk("rst_comb_imm", imm, 32'hFFFF_FFFB);
      @(negedge clk);
      rst = 1'b0;

      // Table: combinational check, then registered check via scoreboard
      foreach (vecs[k]) begin
         @(negedge clk);
         instr       = vecs[k].instr;
         instr_valid = 1'b1;
         #1;
         chk({vecs[k].name, "_imm"}, imm, vecs[k].imm);
         chk({vecs[k].name, "_fmt"}, {29'd0, fmt}, {29'd0, vecs[k].fmt});
         e.imm = vecs[k].imm; e.fmt = vecs[k].fmt;
         sb.push_back(e);
         @(posedge clk);
         #1;
         chk({vecs[k].name, "_valid_q"}, {31'd0, valid_q}, 32'h0000_0001);
         if (sb.size() == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL %s_sb: scoreboard empty", vecs[k].name);
         end else begin
            e = sb.pop_front();
            chk({vecs[k].name, "_imm_q"}, imm_q, e.imm);
            chk({vecs[k].name, "_fmt_q"}, {29'd0, fmt_q}, {29'd0, e.fmt});
         end
      end

      // Hold: valid addi then a bubble carrying a different word
      @(negedge clk);
      instr = 32'hFFB1_0093; instr_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_v1", {31'd0, valid_q}, 32'h0000_0001);
      @(negedge clk);
      instr = 32'h1234_50B7; instr_valid = 1'b0;
      #1;
      chk("bubble_comb_imm", imm, 32'h1234_5000);
      chk("bubble_comb_fmt", {29'd0, fmt}, {29'd0, F_U});
      @(posedge clk); #1;
      chk("hold_valid_q", {31'd0, valid_q}, 32'h0000_0000);
      chk("hold_imm_q", imm_q, 32'hFFFF_FFFB);
      chk("hold_fmt_q", {29'd0, fmt_q}, {29'd0, F_I});

      // Asynchronous reset mid-hold, before any clock edge
      #2;
      rst = 1'b1;
      #1;
      chk("arst_imm_q",   imm_q,            32'h0000_0000);
      chk("arst_fmt_q",   {29'd0, fmt_q},   32'h0000_0000);
      chk("arst_valid_q", {31'd0, valid_q}, 32'h0000_0000);

      // No capture while reset is held, first capture after release
      @(negedge clk);
      instr = 32'hFE30_AC23; instr_valid = 1'b1;
      @(posedge clk); #1;
      chk("inrst_imm_q",   imm_q,            32'h0000_0000);
      chk("inrst_valid_q", {31'd0, valid_q}, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_imm_q",   imm_q,            32'hFFFF_FFF8);
      chk("post_rst_fmt_q",   {29'd0, fmt_q},   {29'd0, F_S});
      chk("post_rst_valid_q", {31'd0, valid_q}, 32'h0000_0001);

      if (sb.size() != 0) begin
         tests_run++; tests_failed++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_imm_gen
